// File: rtl/multi_cnt_obi.sv
// multi_cnt_obi: NumCh-channel prescaled up/down timer on an OBI slave port.
// Per-channel state lives in multi_cnt_obi_ch; the top does address decode,
// byte-lane merging, the read mux, the response stage and the interrupt OR.

module multi_cnt_obi_ch #(
  parameter int CntWidth   = 32,
  parameter int PrescWidth = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_ctrl,     // CTRL write with at least one byte enabled
  input  logic        wr_ctrl_en,  // CTRL write that covers byte 0 (en bit)
  input  logic        wr_thresh,
  input  logic        wr_value,
  input  logic        clr_hit,     // STATUS W1C of bit 0
  input  logic [31:0] wdata,       // already merged with current register contents
  output logic [31:0] ctrl_rd,
  output logic [31:0] thresh_rd,
  output logic [31:0] value_rd,
  output logic        hit,
  output logic        ie
);

  logic                  en, oneshot, down;
  logic [PrescWidth-1:0] presc, pcnt;
  logic [CntWidth-1:0]   thresh, value;
  logic                  tick, at_end, hw_hit;
  logic                  unused_wdata;

  assign unused_wdata = ^wdata;

  // A tick fires when the prescaler reaches its terminal count.
  assign tick   = en && (pcnt == presc);
  assign at_end = down ? (value == '0) : (value == thresh);
  // A software VALUE write on the same edge overrides the tick, so no hit.
  assign hw_hit = tick && at_end && !wr_value;

  // Channel state: config fields, prescaler, counter and sticky hit flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      down    <= 1'b0;
      ie      <= 1'b0;
      presc   <= '0;
      pcnt    <= '0;
      thresh  <= '0;
      value   <= '0;
      hit     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        oneshot <= wdata[1];
        down    <= wdata[2];
        ie      <= wdata[3];
        presc   <= wdata[8 +: PrescWidth];
      end
      // Software write of en beats the one-shot auto-disable.
      if (wr_ctrl_en)             en <= wdata[0];
      else if (hw_hit && oneshot) en <= 1'b0;

      if (wr_thresh) thresh <= wdata[CntWidth-1:0];

      if (wr_value || !en || tick) pcnt <= '0;
      else                         pcnt <= pcnt + 1'b1;

      if (wr_value) begin
        value <= wdata[CntWidth-1:0];
      end else if (tick) begin
        if (at_end) begin
          // One-shot holds the terminal value; auto-reload restarts.
          if (!oneshot) value <= down ? thresh : '0;
        end else begin
          // Up mode past THRESH simply wraps through all-ones without a hit.
          value <= down ? value - 1'b1 : value + 1'b1;
        end
      end

      // Set wins over a same-cycle W1C.
      if (hw_hit)       hit <= 1'b1;
      else if (clr_hit) hit <= 1'b0;
    end
  end

  // Zero-extended register views for the bus read mux.
  always_comb begin
    ctrl_rd                   = '0;
    ctrl_rd[0]                = en;
    ctrl_rd[1]                = oneshot;
    ctrl_rd[2]                = down;
    ctrl_rd[3]                = ie;
    ctrl_rd[8 +: PrescWidth]  = presc;
  end

  assign thresh_rd = 32'(thresh);
  assign value_rd  = 32'(value);

endmodule

module multi_cnt_obi #(
  parameter int NumCh      = 4,
  parameter int CntWidth   = 32,
  parameter int PrescWidth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [31:0]      addr_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  output logic             rvalid_o,
  output logic [31:0]      rdata_o,
  output logic             intr_o,
  output logic [NumCh-1:0] ch_hit_o
);

  typedef struct packed {
    logic        we;
    logic [5:0]  ch;
    logic [1:0]  reg_sel;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

  localparam logic [7:0] IrqWord = 8'(NumCh * 4);

  bus_req_t               req;
  logic [7:0]             word;
  logic                   ch_ok, is_irq, wr;
  logic [31:0]            bmask, rd_word, merged;
  logic [NumCh-1:0][31:0] ctrl_rd, thresh_rd, value_rd;
  logic [NumCh-1:0]       hit, ie, irq_pend;
  logic [NumCh-1:0]       wr_ctrl, wr_ctrl_en, wr_thresh, wr_value, clr_hit;
  logic                   rvalid_q, intr_q;
  logic [31:0]            rdata_q;
  logic                   unused_addr;

  assign unused_addr = ^{addr_i[31:10], addr_i[1:0]};

  assign gnt_o = req_i;
  assign word  = addr_i[9:2];

  assign req.we      = we_i;
  assign req.ch      = word[7:2];
  assign req.reg_sel = word[1:0];
  assign req.be      = be_i;
  assign req.wdata   = wdata_i;

  assign ch_ok  = (int'(req.ch) < NumCh);
  assign is_irq = (word == IrqWord);
  // A write with no byte enables must not disturb anything (notably VALUE,
  // whose write would otherwise clear the prescaler).
  assign wr     = req_i && req.we && (|req.be);

  assign irq_pend = hit & ie;

  // Byte-lane mask from the byte enables.
  always_comb begin
    bmask = '0;
    for (int b = 0; b < 4; b++) bmask[8*b +: 8] = {8{req.be[b]}};
  end

  // Read mux over the addressed register; unmapped offsets read 0.
  always_comb begin
    rd_word = '0;
    if (ch_ok) begin
      for (int c = 0; c < NumCh; c++) begin
        if (req.ch == 6'(c)) begin
          case (req.reg_sel)
            2'd0:    rd_word = ctrl_rd[c];
            2'd1:    rd_word = thresh_rd[c];
            2'd2:    rd_word = value_rd[c];
            default: rd_word = {31'b0, hit[c]};
          endcase
        end
      end
    end else if (is_irq) begin
      rd_word = 32'(irq_pend);
    end
  end

  // Unselected byte lanes keep the register's current contents.
  assign merged = (rd_word & ~bmask) | (req.wdata & bmask);

  // Per-channel write strobes.
  always_comb begin
    wr_ctrl    = '0;
    wr_ctrl_en = '0;
    wr_thresh  = '0;
    wr_value   = '0;
    clr_hit    = '0;
    for (int c = 0; c < NumCh; c++) begin
      if (wr && ch_ok && req.ch == 6'(c)) begin
        wr_ctrl[c]    = (req.reg_sel == 2'd0);
        wr_ctrl_en[c] = (req.reg_sel == 2'd0) && req.be[0];
        wr_thresh[c]  = (req.reg_sel == 2'd1);
        wr_value[c]   = (req.reg_sel == 2'd2);
        clr_hit[c]    = (req.reg_sel == 2'd3) && req.be[0] && req.wdata[0];
      end
    end
  end

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    multi_cnt_obi_ch #(
      .CntWidth   (CntWidth),
      .PrescWidth (PrescWidth)
    ) u_ch (
      .clk        (clk_i),
      .rst        (rst_i),
      .wr_ctrl    (wr_ctrl[c]),
      .wr_ctrl_en (wr_ctrl_en[c]),
      .wr_thresh  (wr_thresh[c]),
      .wr_value   (wr_value[c]),
      .clr_hit    (clr_hit[c]),
      .wdata      (merged),
      .ctrl_rd    (ctrl_rd[c]),
      .thresh_rd  (thresh_rd[c]),
      .value_rd   (value_rd[c]),
      .hit        (hit[c]),
      .ie         (ie[c])
    );
  end

  // Response stage and registered interrupt; reset drops a pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      intr_q   <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= (req_i && !req.we) ? rd_word : '0;
      intr_q   <= |irq_pend;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign intr_o   = intr_q;
  assign ch_hit_o = hit;

endmodule

// File: tb/tb_multi_cnt_obi.sv
// Directed bench for multi_cnt_obi: a table of back-to-back bus vectors with
// hand-computed read data, plus cycle-exact sequences for collisions, wrap,
// reset mid-transaction and multi-channel hit periods.

module tb_multi_cnt_obi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        intr;
  logic [3:0]  ch_hit;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  multi_cnt_obi #(.NumCh(4), .CntWidth(32), .PrescWidth(8)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .addr_i   (addr),
    .we_i     (we),
    .be_i     (be),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .intr_o   (intr),
    .ch_hit_o (ch_hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  // Hit-edge monitor for the multi-channel period test.
  bit          mon_on = 0;
  logic [3:0]  hit_prev = '0;
  int          nrise[4];
  int          trise[4][2];

  initial forever begin
    @(posedge clk);
    #1;
    if (mon_on) begin
      for (int c = 0; c < 4; c++) begin
        if (ch_hit[c] && !hit_prev[c]) begin
          if (nrise[c] < 2) trise[c][nrise[c]] = cyc;
          nrise[c]++;
        end
      end
    end
    hit_prev = ch_hit;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transaction: accepted on the next posedge, response sampled 1ns after.
  task automatic bus(input string tag, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1;
    chk({tag, " gnt"}, 32'(gnt), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, " rvalid"}, 32'(rvalid), 32'd1);
    rd = rdata;
    if (w) chk({tag, " wr_rdata"}, rdata, 32'd0);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] tmp;
    bus(tag, 1'b1, a, 4'hF, d, tmp);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] tmp;
    bus(tag, 1'b0, a, 4'hF, 32'd0, tmp);
    chk(tag, tmp, exp);
  endtask

  function automatic void add(logic w, logic [31:0] a, logic [3:0] b, logic [31:0] d,
                              logic cr, logic [31:0] er, logic ci, logic ei);
    vec_t v;
    v.we = w; v.addr = a; v.be = b; v.wdata = d;
    v.chk_rd = cr; v.exp_rd = er; v.chk_irq = ci; v.exp_irq = ei;
    vecs.push_back(v);
  endfunction

  function automatic void aw(logic [31:0] a, logic [3:0] b, logic [31:0] d);
    add(1'b1, a, b, d, 1'b0, 32'd0, 1'b0, 1'b0);
  endfunction

  function automatic void ar(logic [31:0] a, logic [31:0] e);
    add(1'b0, a, 4'hF, 32'd0, 1'b1, e, 1'b0, 1'b0);
  endfunction

  function automatic void ari(logic [31:0] a, logic [31:0] e, logic ei);
    add(1'b0, a, 4'hF, 32'd0, 1'b1, e, 1'b1, ei);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic bit all_rise(int n);
    for (int c = 0; c < 4; c++) if (nrise[c] < n) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic [31:0] tmp;
    int ec[4];
    int pv[4];
    int tv[4];

    // Reset state.
    do_reset();
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst intr", 32'(intr), 32'd0);
    chk("rst ch_hit", 32'(ch_hit), 32'd0);

    // All channel registers read 0 after reset.
    for (int c = 0; c < 4; c++) begin
      ari(32'(c * 16 + 0), 32'd0, 1'b0);
      ari(32'(c * 16 + 8), 32'd0, 1'b0);
      ari(32'(c * 16 + 12), 32'd0, 1'b0);
    end
    // ch0 up auto-reload, THRESH=3, presc 0, en+ie.
    aw(32'h04, 4'hF, 32'd3);
    aw(32'h00, 4'hF, 32'h9);
    ar(32'h08, 32'd0);
    ar(32'h08, 32'd1);
    ar(32'h08, 32'd2);
    ari(32'h08, 32'd3, 1'b0);   // hit sets on this edge (3 -> 0)
    ari(32'h0C, 32'd1, 1'b1);   // intr one cycle later
    ari(32'h40, 32'd1, 1'b1);
    aw(32'h00, 4'hF, 32'h8);    // stop, keep ie
    add(1'b1, 32'h0C, 4'h1, 32'd1, 1'b0, 32'd0, 1'b1, 1'b1);
    ari(32'h0C, 32'd0, 1'b0);
    ar(32'h08, 32'd3);
    // ch1 one-shot down, presc 1, VALUE=2.
    aw(32'h18, 4'hF, 32'd2);
    aw(32'h10, 4'hF, 32'h107);
    ar(32'h18, 32'd2);
    ar(32'h18, 32'd2);
    ar(32'h18, 32'd1);
    ar(32'h18, 32'd1);
    ar(32'h18, 32'd0);
    ar(32'h1C, 32'd0);
    ar(32'h1C, 32'd1);
    ari(32'h10, 32'h106, 1'b0);
    ar(32'h18, 32'd0);
    // Byte enables and unmapped space on ch2.
    aw(32'h24, 4'b0010, 32'hAABBCCDD);
    ar(32'h24, 32'h0000CC00);
    aw(32'h24, 4'b0000, 32'h12345678);
    ar(32'h24, 32'h0000CC00);
    ar(32'h3FC, 32'd0);
    aw(32'h3FC, 4'hF, 32'hFFFFFFFF);
    ar(32'h24, 32'h0000CC00);
    ar(32'h20, 32'd0);
    ar(32'h28, 32'd0);
    ar(32'h44, 32'd0);
    aw(32'h20, 4'b0010, 32'h00000500);
    ar(32'h20, 32'h00000500);
    ar(32'h40, 32'd0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      bus(tag, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, tmp);
      if (vecs[i].chk_rd)  chk({tag, " rdata"}, tmp, vecs[i].exp_rd);
      if (vecs[i].chk_irq) chk({tag, " intr"}, 32'(intr), 32'(vecs[i].exp_irq));
    end
    chk("ch_hit after table", 32'(ch_hit), 32'h2);
    @(posedge clk);
    #1;
    chk("rvalid idle", 32'(rvalid), 32'd0);

    // Collisions on ch3.
    do_reset();
    // VALUE write on a would-be hit tick: SW value wins, no hit.
    wr("c1 thr", 32'h34, 32'd5);
    wr("c1 val", 32'h38, 32'd5);
    wr("c1 en", 32'h30, 32'h1);
    wr("c1 val2", 32'h38, 32'h40);
    rd("c1 value", 32'h38, 32'h40);
    rd("c1 status", 32'h3C, 32'd0);
    wr("c1 stop", 32'h30, 32'h0);
    rd("c1 held", 32'h38, 32'h43);
    // W1C on the hit-set edge: set wins.
    wr("c2 thr", 32'h34, 32'd2);
    wr("c2 val", 32'h38, 32'd2);
    wr("c2 en", 32'h30, 32'h1);
    wr("c2 w1c", 32'h3C, 32'd1);
    wr("c2 stop", 32'h30, 32'h0);
    rd("c2 status", 32'h3C, 32'd1);
    wr("c2 w1c2", 32'h3C, 32'd1);
    rd("c2 cleared", 32'h3C, 32'd0);
    // CTRL.en=1 write on a one-shot auto-clear: SW wins.
    wr("c3 thr", 32'h34, 32'd1);
    wr("c3 val", 32'h38, 32'd1);
    wr("c3 en", 32'h30, 32'h3);
    wr("c3 en2", 32'h30, 32'h3);
    rd("c3 ctrl kept", 32'h30, 32'h3);
    rd("c3 ctrl clr", 32'h30, 32'h2);
    rd("c3 value", 32'h38, 32'd1);
    rd("c3 status", 32'h3C, 32'd1);

    // Up-mode wrap past all-ones without a hit.
    wr("w w1c", 32'h3C, 32'd1);
    wr("w thr", 32'h34, 32'd2);
    wr("w val", 32'h38, 32'hFFFFFFFE);
    wr("w en", 32'h30, 32'h1);
    rd("w st0", 32'h3C, 32'd0);
    rd("w ff", 32'h38, 32'hFFFFFFFF);
    rd("w st1", 32'h3C, 32'd0);
    rd("w v1", 32'h38, 32'd1);
    rd("w v2", 32'h38, 32'd2);
    rd("w hit", 32'h3C, 32'd1);

    // Reset asserted on an accept edge drops the response.
    @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h3C; be = 4'hF;
    @(posedge clk);
    #1;
    chk("rstmid rvalid", 32'(rvalid), 32'd0);
    chk("rstmid rdata", rdata, 32'd0);
    chk("rstmid ch_hit", 32'(ch_hit), 32'd0);
    chk("rstmid intr", 32'(intr), 32'd0);
    req = 1'b0; rst = 1'b0;

    // Multi-channel periods: (presc+1)*(THRESH+1).
    pv = '{1, 2, 3, 4};
    tv = '{9, 6, 5, 4};
    for (int c = 0; c < 4; c++) nrise[c] = 0;
    for (int c = 0; c < 4; c++) wr($sformatf("m thr%0d", c), 32'(c * 16 + 4), 32'(tv[c]));
    mon_on = 1;
    for (int c = 0; c < 4; c++) begin
      // ie only on even channels.
      wr($sformatf("m ctrl%0d", c), 32'(c * 16), 32'((pv[c] << 8) | ((c % 2 == 0) ? 9 : 1)));
      ec[c] = cyc;
    end
    for (int i = 0; i < 200; i++) begin
      if (all_rise(1)) break;
      @(posedge clk);
    end
    chk("m first hits seen", 32'(all_rise(1)), 32'd1);
    rd("m irq_pend", 32'h40, 32'h5);
    chk("m intr", 32'(intr), 32'd1);
    for (int c = 0; c < 4; c++) begin
      logic [31:0] t2;
      bus($sformatf("m w1c%0d", c), 1'b1, 32'(c * 16 + 12), 4'h1, 32'd1, t2);
    end
    for (int i = 0; i < 200; i++) begin
      if (all_rise(2)) break;
      @(posedge clk);
    end
    chk("m second hits seen", 32'(all_rise(2)), 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("m ch%0d first", c), 32'(trise[c][0] - ec[c]), 32'((pv[c] + 1) * (tv[c] + 1)));
      chk($sformatf("m ch%0d period", c), 32'(trise[c][1] - trise[c][0]), 32'((pv[c] + 1) * (tv[c] + 1)));
    end
    mon_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
